// File: rtl/fault_ticker_mc.sv
// fault_ticker_mc: multi-channel fault indicator ticker with LED pattern.
// Define FAULT_STICKY_EN to latch faults until a clr pulse.
module fault_ticker_mc #(
    parameter int NCH         = 4,
    parameter int LED_W       = 3,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int ID_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   fault,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic [LED_W-1:0] led,
    output logic             active,
    output logic [ID_W-1:0]  fault_id
);

    localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    logic [NCH-1:0]   eff;
    logic [NCH-1:0]   f_q;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             tick;
    logic [LED_W-1:0] led_step;
    logic [LED_W-1:0] led_init;
    logic [ID_W-1:0]  id_nxt;

`ifdef FAULT_STICKY_EN
    logic [NCH-1:0] lat;

    // A fault asserted together with clr wins and stays latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat <= '0;
        end else begin
            lat <= (lat & ~{NCH{clr}}) | fault;
        end
    end

    assign eff = lat;
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign eff        = fault;
`endif

    assign rise     = |(eff & ~f_q);
    assign tick     = (cnt == CNT_MAX);
    assign led_init = mode[1] ? {LED_W{1'b1}} : LED_W'(1);

    always_comb begin
        led_step = led;
        case (mode)
            2'b00:   led_step = {led[LED_W-2:0], led[LED_W-1]};
            2'b01:   led_step = {led[0], led[LED_W-1:1]};
            2'b10:   led_step = ~led;
            default: led_step = led;
        endcase
    end

    // Scan downwards so the lowest active index is the last assignment.
    always_comb begin
        id_nxt = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (eff[i]) id_nxt = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q      <= '0;
            active   <= 1'b0;
            fault_id <= '0;
        end else begin
            f_q      <= eff;
            active   <= |eff;
            fault_id <= id_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
            cnt <= '0;
        end else if (eff == '0) begin
            led <= '0;
            cnt <= '0;
        end else if (rise) begin
            led <= led_init;
            cnt <= '0;
        end else if (tick) begin
            led <= led_step;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fault_ticker_mc.sv
// tb_fault_ticker_mc: directed and random checks of fault_ticker_mc
// against a cycle-level behavioural model.
module tb_fault_ticker_mc;

    localparam int TK = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] fault;
    logic [1:0] mode;
    logic       clr;
    logic [2:0] led;
    logic       active;
    logic [1:0] fault_id;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pattern value, cycles since last restart/step,
    // previous effective vector and the sticky latch.
    int       m_led;
    int       m_age;
    logic [3:0] m_prev;
    logic [3:0] m_lat;
    int       m_act;
    int       m_id;

    fault_ticker_mc #(
        .NCH(4),
        .LED_W(3),
        .TICK_CYCLES(TK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fault(fault),
        .mode(mode),
        .clr(clr),
        .led(led),
        .active(active),
        .fault_id(fault_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_led  = 0;
        m_age  = 0;
        m_prev = '0;
        m_lat  = '0;
        m_act  = 0;
        m_id   = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".led"}, int'(led), m_led);
        chk({tag, ".active"}, int'(active), m_act);
        chk({tag, ".id"}, int'(fault_id), m_id);
    endtask

    // One clock: compute expected state from pre-edge inputs, then compare.
    task automatic cyc(input string tag);
        logic [3:0] e;
        int nl;
        int na;
        e = fault;
`ifdef FAULT_STICKY_EN
        e = m_lat;
`endif
        nl = m_led;
        na = m_age;
        if (e == 0) begin
            nl = 0;
            na = 0;
        end else if ((e & ~m_prev) != 0) begin
            nl = mode[1] ? 7 : 1;
            na = 0;
        end else begin
            na = m_age + 1;
            if (na == TK) begin
                na = 0;
                case (mode)
                    2'd0: nl = (m_led * 2) % 8 + m_led / 4;
                    2'd1: nl = m_led / 2 + (m_led % 2) * 4;
                    2'd2: nl = 7 - m_led;
                    default: nl = m_led;
                endcase
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_led = nl;
            m_age = na;
            m_act = (e != 0) ? 1 : 0;
            m_id  = 0;
            for (int i = 3; i >= 0; i--) if (e[i]) m_id = i;
            m_prev = e;
            m_lat  = (m_lat & ~{4{clr}}) | fault;
        end
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        fault = '0;
        mode  = 2'b00;
        clr   = 1'b0;
        model_reset();
        #1;
        chk("rst.led", int'(led), 0);
        chk("rst.active", int'(active), 0);
        chk("rst.id", int'(fault_id), 0);
        cyc("rst_hold");
        rst_n = 1'b1;
        cyc("idle");

        // Rotate left, then async reset while led=010
        fault = 4'b0001;
        cyc("rotl");
        chk("rotl.restart", int'(led), 1);
        repeat (4) cyc("rotl");
        chk("rotl.step1", int'(led), 2);
        rst_n = 1'b0;
        #1;
        chk("arst.led", int'(led), 0);
        chk("arst.active", int'(active), 0);
        chk("arst.id", int'(fault_id), 0);
        model_reset();
        cyc("arst_hold");
        rst_n = 1'b1;
        cyc("rise_after_rst");
        chk("rise_after_rst.led", int'(led), 1);
        repeat (12) cyc("rotl");

        // Rotate right from a fresh restart
        fault = 4'b0000;
        mode  = 2'b01;
        cyc("drop");
        fault = 4'b0001;
        repeat (9) cyc("rotr");
        chk("rotr.step2", int'(led), 2);

        // Re-trigger by a second channel, then drop the first
        fault = 4'b0000;
        mode  = 2'b00;
        cyc("drop");
        fault = 4'b0001;
        repeat (9) cyc("retrig_pre");
        chk("retrig_pre.led", int'(led), 4);
        fault = 4'b0101;
        cyc("retrig");
        chk("retrig.led", int'(led), 1);
        chk("retrig.id", int'(fault_id), 0);
        fault = 4'b0100;
        cyc("retrig_drop");
        chk("retrig_drop.id", int'(fault_id), 2);

        // Collision of rise with tick: restart wins
        fault = 4'b0000;
        cyc("drop");
        fault = 4'b0001;
        repeat (4) cyc("coll_pre");
        fault = 4'b1001;
        cyc("coll");
        chk("coll.led", int'(led), 1);
        repeat (3) cyc("coll_hold");
        chk("coll.hold", int'(led), 1);
        cyc("coll_step");
        chk("coll.step", int'(led), 2);

        // Blink, solid, then all faults drop
        fault = 4'b0000;
        mode  = 2'b10;
        cyc("drop");
        fault = 4'b0010;
        repeat (13) cyc("blink");
        mode = 2'b11;
        repeat (9) cyc("solid");
        fault = 4'b0000;
        cyc("alldrop");
        chk("alldrop.led", int'(led), 0);
        chk("alldrop.active", int'(active), 0);

`ifdef FAULT_STICKY_EN
        mode = 2'b00;
        fault = 4'b0010;
        cyc("sticky_pulse");
        fault = 4'b0000;
        repeat (10) cyc("sticky_hold");
        chk("sticky.active", int'(active), 1);
        clr = 1'b1;
        cyc("sticky_clr");
        clr = 1'b0;
        cyc("sticky_clr2");
        chk("sticky_clr.led", int'(led), 0);
        fault = 4'b0010;
        cyc("sticky_set");
        clr = 1'b1;
        cyc("sticky_both");
        clr = 1'b0;
        fault = 4'b0000;
        repeat (3) cyc("sticky_kept");
        chk("sticky_kept.active", int'(active), 1);
        clr = 1'b1;
        cyc("sticky_clr3");
        clr = 1'b0;
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) fault = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            clr = ($urandom_range(7) == 0);
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
